// File: rtl/div_seq_ctrl_if.sv
// Request/response bundle for the sequential divider.
// The upstream master drives the operands and the result acceptance.
// The divider slave returns the handshakes, the result and its status.
interface div_seq_ctrl_if #(
  parameter int WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz, busy
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider with its own controller.
// Each clock in CALC produces one quotient bit, MSB first.
// A divisor of zero short-cuts straight to DONE:
//   - the quotient reads as all ones,
//   - the remainder reads back as the dividend,
//   - dbz is set.
module div_seq_ctrl #(
  parameter int WIDTH = 6
) (
  input logic          clk,
  input logic          rst_n,
  div_seq_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH:0]   r_reg;
  logic [CNT_W-1:0] cnt;
  logic             dbz_reg;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic             r_top_unused;

  // One restoring step:
  //   - shift the next dividend bit into the partial remainder;
  //   - compare and subtract at full WIDTH+1 width, so there is never an overflow.
  assign trial = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
  assign diff  = trial - {1'b0, d_reg};
  assign fits  = (trial >= {1'b0, d_reg});

  // The partial remainder always stays below the divisor.
  // Its top bit is therefore structurally zero and is never read.
  assign r_top_unused = r_reg[WIDTH];

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.quotient  = q_reg;
  assign bus.remainder = r_reg[WIDTH-1:0];
  assign bus.dbz       = dbz_reg;

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode:
  //   - accept only in IDLE;
  //   - leave CALC on the last step;
  //   - release DONE when the result is taken.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.divisor == '0) state_nxt = DONE;
          else                   state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath:
  //   - capture operands on accept;
  //   - run one step per CALC cycle;
  //   - hold the result everywhere else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg   <= '0;
      d_reg   <= '0;
      r_reg   <= '0;
      cnt     <= '0;
      dbz_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            d_reg <= bus.divisor;
            if (bus.divisor == '0) begin
              q_reg   <= '1;
              r_reg   <= {1'b0, bus.dividend};
              cnt     <= '0;
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= bus.dividend;
              r_reg   <= '0;
              cnt     <= CNT_W'(WIDTH);
              dbz_reg <= 1'b0;
            end
          end
        end
        CALC: begin
          q_reg <= {q_reg[WIDTH-2:0], fits};
          r_reg <= fits ? diff : trial;
          cnt   <= cnt - CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed and randomised self-checking bench for div_seq_ctrl.
// Expected values are hand-computed constants, plus a plain arithmetic reference for the random pass.
module tb_div_seq_ctrl;
  localparam int WIDTH = 6;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             d;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  res_t sb[$];

  logic [WIDTH-1:0] t2_a [4] = '{6'd63, 6'd10, 6'd0, 6'd63};
  logic [WIDTH-1:0] t2_b [4] = '{6'd1,  6'd63, 6'd5, 6'd63};
  logic [WIDTH-1:0] t2_q [4] = '{6'd63, 6'd0,  6'd0, 6'd1};
  logic [WIDTH-1:0] t2_r [4] = '{6'd0,  6'd10, 6'd0, 6'd0};

  div_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  div_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Edge counter used to measure accept spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard time limit so the run can never hang.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair, wait (bounded) for in_ready, and pass the accept edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input bit keep, output int acc_cyc);
    int n;
    n = 0;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL send_ready_timeout: in_ready=%b required 1", bus.in_ready);
    end
    tick();
    acc_cyc = cyc;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  // Count edges (bounded) until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL result_timeout: out_valid=%b required 1", bus.out_valid);
    end
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    tick();
    tick();
    checks += 6;
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", bus.busy); end
    if (bus.quotient !== 6'd0) begin errors++; $display("[TB] FAIL reset_quotient: got %0d required 0", bus.quotient); end
    if (bus.remainder !== 6'd0) begin errors++; $display("[TB] FAIL reset_remainder: got %0d required 0", bus.remainder); end
    if (bus.dbz !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b required 0", bus.dbz); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int acc;
    int lat;
    int ir_low;
    bus.out_ready = 1'b1;
    send(6'd45, 6'd7, 1'b0, acc);
    lat    = 0;
    ir_low = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      if (bus.in_ready === 1'b0) ir_low++;
      tick();
      lat++;
    end
    if (bus.in_ready === 1'b0) ir_low++;
    checks += 6;
    if (lat !== WIDTH) begin errors++; $display("[TB] FAIL basic_latency: got %0d required %0d", lat, WIDTH); end
    if (bus.quotient !== 6'd6) begin errors++; $display("[TB] FAIL basic_quotient: got %0d required 6", bus.quotient); end
    if (bus.remainder !== 6'd3) begin errors++; $display("[TB] FAIL basic_remainder: got %0d required 3", bus.remainder); end
    if (bus.dbz !== 1'b0) begin errors++; $display("[TB] FAIL basic_dbz: got %b required 0", bus.dbz); end
    if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b required 1", bus.busy); end
    if (ir_low !== 7) begin errors++; $display("[TB] FAIL basic_in_ready_low: got %0d cycles required 7", ir_low); end
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_out_valid_pulse: got %b required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready_return: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back;
    int acc;
    int prev;
    int lat;
    int n;
    bus.out_ready = 1'b1;
    bus.dividend  = t2_a[0];
    bus.divisor   = t2_b[0];
    bus.in_valid  = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_%0d: got %b required 1", i, bus.in_ready); end
      tick();
      acc = cyc;
      if (i < 3) begin
        bus.dividend = t2_a[i+1];
        bus.divisor  = t2_b[i+1];
      end else begin
        bus.in_valid = 1'b0;
        bus.dividend = 6'd33;
        bus.divisor  = 6'd0;
      end
      if (i > 0) begin
        checks++;
        if (acc - prev !== WIDTH + 2) begin errors++; $display("[TB] FAIL b2b_gap_%0d: got %0d required %0d", i, acc - prev, WIDTH + 2); end
      end
      prev = acc;
      wait_result(lat);
      checks += 4;
      if (lat !== WIDTH) begin errors++; $display("[TB] FAIL b2b_latency_%0d: got %0d required %0d", i, lat, WIDTH); end
      if (bus.quotient !== t2_q[i]) begin errors++; $display("[TB] FAIL b2b_quotient_%0d: got %0d required %0d", i, bus.quotient, t2_q[i]); end
      if (bus.remainder !== t2_r[i]) begin errors++; $display("[TB] FAIL b2b_remainder_%0d: got %0d required %0d", i, bus.remainder, t2_r[i]); end
      if (bus.dbz !== 1'b0) begin errors++; $display("[TB] FAIL b2b_dbz_%0d: got %b required 0", i, bus.dbz); end
      tick();
    end
  endtask

  task automatic test_div_by_zero;
    int acc;
    int lat;
    bus.out_ready = 1'b1;
    send(6'd5, 6'd0, 1'b0, acc);
    wait_result(lat);
    checks += 4;
    if (lat !== 0) begin errors++; $display("[TB] FAIL dbz_latency: got %0d required 0", lat); end
    if (bus.quotient !== 6'd63) begin errors++; $display("[TB] FAIL dbz_quotient: got %0d required 63", bus.quotient); end
    if (bus.remainder !== 6'd5) begin errors++; $display("[TB] FAIL dbz_remainder: got %0d required 5", bus.remainder); end
    if (bus.dbz !== 1'b1) begin errors++; $display("[TB] FAIL dbz_flag: got %b required 1", bus.dbz); end
    tick();
    send(6'd12, 6'd4, 1'b0, acc);
    wait_result(lat);
    checks += 3;
    if (bus.quotient !== 6'd3) begin errors++; $display("[TB] FAIL after_dbz_quotient: got %0d required 3", bus.quotient); end
    if (bus.remainder !== 6'd0) begin errors++; $display("[TB] FAIL after_dbz_remainder: got %0d required 0", bus.remainder); end
    if (bus.dbz !== 1'b0) begin errors++; $display("[TB] FAIL after_dbz_flag: got %b required 0", bus.dbz); end
    tick();
  endtask

  task automatic test_backpressure;
    int acc;
    int lat;
    bus.out_ready = 1'b0;
    send(6'd50, 6'd9, 1'b0, acc);
    wait_result(lat);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder} !== {1'b1, 1'b0, 6'd5, 6'd5})
      begin
        errors++;
        $display("[TB] FAIL hold_%0d: got valid=%b ready=%b q=%0d r=%0d required valid=1 ready=0 q=5 r=5",
                 k, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_out_valid: got %b required 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready: got %b required 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_calc;
    int acc;
    int lat;
    bus.out_ready = 1'b1;
    send(6'd45, 6'd7, 1'b0, acc);
    bus.dividend  = 6'd1;
    bus.out_ready = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    checks += 6;
    if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b required 0", bus.out_valid); end
    if (bus.quotient !== 6'd0) begin errors++; $display("[TB] FAIL midrst_quotient: got %0d required 0", bus.quotient); end
    if (bus.remainder !== 6'd0) begin errors++; $display("[TB] FAIL midrst_remainder: got %0d required 0", bus.remainder); end
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b required 0", bus.busy); end
    if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_in_ready: got %b required 1", bus.in_ready); end
    if (bus.dbz !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dbz: got %b required 0", bus.dbz); end
    rst_n = 1'b1;
    tick();
    send(6'd20, 6'd3, 1'b0, acc);
    wait_result(lat);
    checks += 2;
    if (bus.quotient !== 6'd6) begin errors++; $display("[TB] FAIL fresh_quotient: got %0d required 6", bus.quotient); end
    if (bus.remainder !== 6'd2) begin errors++; $display("[TB] FAIL fresh_remainder: got %0d required 2", bus.remainder); end
    tick();
  endtask

  task automatic test_random;
    int   accepted;
    int   received;
    int   budget;
    res_t e;
    res_t got;
    accepted = 0;
    received = 0;
    budget   = 0;
    sb.delete();
    while ((accepted < 1000 || sb.size() != 0) && budget < 40000) begin
      if (accepted < 1000) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.dividend = 6'($urandom_range(0, 63));
        bus.divisor  = ($urandom_range(0, 15) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
        checks++;
        if (sb.size() != 0) begin
          errors++;
          $display("[TB] FAIL rand_accept_while_busy: pending=%0d required 0", sb.size());
        end
        if (bus.divisor == 6'd0) begin
          e.q = 6'd63;
          e.r = bus.dividend;
          e.d = 1'b1;
        end else begin
          e.q = bus.dividend / bus.divisor;
          e.r = bus.dividend % bus.divisor;
          e.d = 1'b0;
        end
        sb.push_back(e);
        accepted++;
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rand_spurious_result: q=%0d r=%0d with nothing pending", bus.quotient, bus.remainder);
        end else begin
          got.q = bus.quotient;
          got.r = bus.remainder;
          got.d = bus.dbz;
          e     = sb.pop_front();
          checks += 3;
          if (got.q !== e.q) begin errors++; $display("[TB] FAIL rand_quotient_%0d: got %0d required %0d", received, got.q, e.q); end
          if (got.r !== e.r) begin errors++; $display("[TB] FAIL rand_remainder_%0d: got %0d required %0d", received, got.r, e.r); end
          if (got.d !== e.d) begin errors++; $display("[TB] FAIL rand_dbz_%0d: got %b required %b", received, got.d, e.d); end
          received++;
        end
      end
      tick();
      budget++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (received !== 1000) begin
      errors++;
      $display("[TB] FAIL rand_result_count: got %0d required 1000", received);
    end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
